// File: rtl/led_strobe_gen.sv
// led_strobe_gen: strobe/flash LED pattern engine.
// Drives two LED groups (A = upper half, B = lower half) through OFF, ALT,
// ALL and BURST patterns. Each step lasts a configurable number of ticks.
// Mode, period and burst count are sampled only when a pattern cycle starts,
// so a pattern cycle always completes with the configuration it began with.
module led_strobe_gen #(
    parameter int N_LED   = 8,
    parameter int CNT_W   = 10,
    parameter int BURST_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [BURST_W-1:0] burst_n,
    input  logic [N_LED-1:0]   led_select,
    output logic [N_LED-1:0]   led_out,
    output logic               busy,
    output logic               grp_b
);

    localparam int HALF = N_LED / 2;

    localparam logic [N_LED-1:0]   PAT_A   = {{HALF{1'b1}}, {HALF{1'b0}}};
    localparam logic [N_LED-1:0]   PAT_B   = {{HALF{1'b0}}, {HALF{1'b1}}};
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [BURST_W-1:0] BN_ONE  = BURST_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_ON,
        S_A_OFF,
        S_B_ON,
        S_B_OFF
    } state_e;

    typedef enum logic [1:0] {
        M_OFF,
        M_ALT,
        M_ALL,
        M_BURST
    } mode_e;

    // FSM state, step/burst counters and latched configuration
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BURST_W-1:0] bcnt_q,  bcnt_d;
    mode_e              mode_q,  mode_d;
    logic [CNT_W-1:0]   per_q,   per_d;
    logic [BURST_W-1:0] bn_q,    bn_d;

    // Registered outputs
    logic [N_LED-1:0]   led_q,   led_d;
    logic               busy_q,  busy_d;
    logic               grpb_q,  grpb_d;

    // Zero-substituted configuration inputs and step/burst end detection
    logic [CNT_W-1:0]   per_fix;
    logic [BURST_W-1:0] bn_fix;
    logic               step_last;
    logic               burst_last;
    logic               boundary;

    assign per_fix    = (period  == '0) ? CNT_ONE : period;
    assign bn_fix     = (burst_n == '0) ? BN_ONE  : burst_n;
    assign step_last  = (cnt_q  == (per_q - CNT_ONE));
    assign burst_last = (bcnt_q == (bn_q  - BN_ONE));

    // State register: FSM state, counters and latched configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            mode_q  <= M_OFF;
            per_q   <= '0;
            bn_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            mode_q  <= mode_d;
            per_q   <= per_d;
            bn_q    <= bn_d;
        end
    end

    // Next-state logic: step timing, pattern sequencing and config latching.
    // Every path that ends a pattern cycle (IDLE exit included) raises
    // boundary; the shared block at the bottom then re-latches the config
    // and picks IDLE or A_ON from the freshly sampled mode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        mode_d   = mode_q;
        per_d    = per_q;
        bn_d     = bn_q;
        boundary = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bcnt_d  = '0;
        end else if (state_q == S_IDLE) begin
            if (mode != 2'd0) begin
                boundary = 1'b1;
            end
        end else if (!step_last) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = '0;
            unique case (state_q)
                S_A_ON: begin
                    state_d = (mode_q == M_ALT) ? S_B_ON : S_A_OFF;
                end
                S_A_OFF: begin
                    if (mode_q == M_BURST) begin
                        if (burst_last) begin
                            state_d = S_B_ON;
                            bcnt_d  = '0;
                        end else begin
                            state_d = S_A_ON;
                            bcnt_d  = bcnt_q + BN_ONE;
                        end
                    end else begin
                        boundary = 1'b1;
                    end
                end
                S_B_ON: begin
                    if (mode_q == M_BURST) begin
                        state_d = S_B_OFF;
                    end else begin
                        boundary = 1'b1;
                    end
                end
                S_B_OFF: begin
                    if (burst_last) begin
                        boundary = 1'b1;
                    end else begin
                        state_d = S_B_ON;
                        bcnt_d  = bcnt_q + BN_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (boundary) begin
            mode_d  = mode_e'(mode);
            per_d   = per_fix;
            bn_d    = bn_fix;
            cnt_d   = '0;
            bcnt_d  = '0;
            state_d = (mode == 2'd0) ? S_IDLE : S_A_ON;
        end
    end

    // Output decode from the upcoming state so outputs change on the same edge
    always_comb begin
        led_d  = '0;
        busy_d = (state_d != S_IDLE);
        grpb_d = (state_d == S_B_ON) || (state_d == S_B_OFF);
        unique case (state_d)
            S_A_ON:  led_d = ((mode_d == M_ALL) ? {N_LED{1'b1}} : PAT_A) & led_select;
            S_B_ON:  led_d = PAT_B & led_select;
            default: led_d = '0;
        endcase
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q  <= '0;
            busy_q <= 1'b0;
            grpb_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            busy_q <= busy_d;
            grpb_q <= grpb_d;
        end
    end

    assign led_out = led_q;
    assign busy    = busy_q;
    assign grp_b   = grpb_q;

endmodule

// File: tb/tb_led_strobe_gen.sv
// Testbench for led_strobe_gen: directed scenarios followed by random
// stimulus, every clock checked against a step-schedule reference model.
module tb_led_strobe_gen;

    localparam int N_LED   = 8;
    localparam int CNT_W   = 10;
    localparam int BURST_W = 3;

    // Step kinds used by the reference schedule
    localparam int K_AON  = 1;
    localparam int K_AOFF = 2;
    localparam int K_BON  = 3;
    localparam int K_BOFF = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   period;
    logic [BURST_W-1:0] burst_n;
    logic [N_LED-1:0]   led_select;
    logic [N_LED-1:0]   led_out;
    logic               busy;
    logic               grp_b;

    int total = 0;
    int bad   = 0;

    // Reference model state: one queue entry per remaining clock of the cycle
    int               sched[$];
    int               m_mode;
    logic [N_LED-1:0] e_led;
    logic             e_busy;
    logic             e_grpb;

    always #5 clk = ~clk;

    led_strobe_gen #(
        .N_LED  (N_LED),
        .CNT_W  (CNT_W),
        .BURST_W(BURST_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .period    (period),
        .burst_n   (burst_n),
        .led_select(led_select),
        .led_out   (led_out),
        .busy      (busy),
        .grp_b     (grp_b)
    );

    function automatic void model_reset();
        sched.delete();
        m_mode = 0;
        e_led  = '0;
        e_busy = 1'b0;
        e_grpb = 1'b0;
    endfunction

    // Expand one whole pattern cycle into a per-clock list of step kinds
    function automatic void model_build();
        int p;
        int b;
        int steps[$];
        p      = (period  == 0) ? 1 : int'(period);
        b      = (burst_n == 0) ? 1 : int'(burst_n);
        m_mode = int'(mode);
        if (m_mode == 1) begin
            steps.push_back(K_AON);
            steps.push_back(K_BON);
        end else if (m_mode == 2) begin
            steps.push_back(K_AON);
            steps.push_back(K_AOFF);
        end else begin
            for (int i = 0; i < b; i++) begin
                steps.push_back(K_AON);
                steps.push_back(K_AOFF);
            end
            for (int i = 0; i < b; i++) begin
                steps.push_back(K_BON);
                steps.push_back(K_BOFF);
            end
        end
        foreach (steps[s]) begin
            for (int c = 0; c < p; c++) sched.push_back(steps[s]);
        end
    endfunction

    // Expected outputs after the current rising edge
    function automatic void model_step();
        int k;
        logic [N_LED-1:0] pat;
        if (!en) begin
            model_reset();
            return;
        end
        if (sched.size() == 0) begin
            if (mode == 2'd0) begin
                model_reset();
                return;
            end
            model_build();
        end
        k = sched.pop_front();
        case (k)
            K_AON:   pat = (m_mode == 2) ? 8'hFF : 8'hF0;
            K_BON:   pat = 8'h0F;
            default: pat = 8'h00;
        endcase
        e_led  = pat & led_select;
        e_busy = 1'b1;
        e_grpb = (k == K_BON) || (k == K_BOFF);
    endfunction

    task automatic check_outputs(input string tag);
        total++;
        assert (led_out === e_led) else begin
            bad++;
            $error("FAIL %s led_out got=%h exp=%h", tag, led_out, e_led);
        end
        total++;
        assert (busy === e_busy) else begin
            bad++;
            $error("FAIL %s busy got=%b exp=%b", tag, busy, e_busy);
        end
        total++;
        assert (grp_b === e_grpb) else begin
            bad++;
            $error("FAIL %s grp_b got=%b exp=%b", tag, grp_b, e_grpb);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Reset pulse placed between rising edges; outputs must clear at once
    task automatic async_reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        total++;
        assert (led_out === 8'h00) else begin
            bad++;
            $error("FAIL async_rst_led got=%h exp=%h", led_out, 8'h00);
        end
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        mode       = 2'd1;
        period     = 10'd3;
        burst_n    = 3'd2;
        led_select = 8'hFF;
        model_reset();

        // Reset held with en=1, mode=ALT
        run(3, "reset_hold");
        rst_n = 1'b1;

        // First A_ON arrives one clock after release
        tick("first_aon");
        total++;
        assert (led_out === 8'hF0) else begin
            bad++;
            $error("FAIL first_aon_led got=%h exp=%h", led_out, 8'hF0);
        end

        // Into the second clock of B_ON, then request ALL
        run(4, "alt");
        total++;
        assert (grp_b === 1'b1 && led_out === 8'h0F) else begin
            bad++;
            $error("FAIL alt_bon got=%b/%h exp=%b/%h", grp_b, led_out, 1'b1, 8'h0F);
        end
        mode = 2'd2;
        run(12, "alt_to_all");

        // BURST, period 2, two flashes per group
        mode    = 2'd3;
        period  = 10'd2;
        burst_n = 3'd2;
        run(40, "burst");

        // Enable drop and restart
        mode   = 2'd1;
        period = 10'd3;
        run(10, "alt2");
        en = 1'b0;
        tick("en_low");
        total++;
        assert (led_out === 8'h00 && busy === 1'b0) else begin
            bad++;
            $error("FAIL en_low_idle got=%h/%b exp=%h/%b", led_out, busy, 8'h00, 1'b0);
        end
        en = 1'b1;
        run(10, "restart");

        // Zero period/burst count, ALL, sparse mask, then reset mid-run
        period     = '0;
        burst_n    = '0;
        mode       = 2'd2;
        led_select = 8'h81;
        run(14, "all_p0");
        async_reset_pulse();
        run(8, "after_rst");

        // Mask change with no state change, BURST with zero burst count
        mode = 2'd3;
        run(6, "burst_b0");
        led_select = 8'h3C;
        run(6, "mask_chg");

        // Random stimulus
        for (int i = 0; i < 1200; i++) begin
            en = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) period = CNT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) burst_n = BURST_W'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) led_select = 8'($urandom);
            tick("random");
            if ($urandom_range(0, 199) == 0) async_reset_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_strobe_gen.md
Name: led_strobe_gen

Overview:
- Parametrised strobe/flash LED pattern engine. Next generation of the fixed 8-LED alternating-half blinker.
- Adds configurable LED count, step period, enable, four run-time modes and a police-style burst mode.
- Sits between the mode-select logic and the LED pins. Driven by the slow system tick clock, same as the other LED mode drivers.

Parameters:
- N_LED, 8, number of LEDs. Must be even and >= 2. Group A = upper N_LED/2 bits, group B = lower N_LED/2 bits.
- CNT_W, 10, width of the period input and of the internal step counter.
- BURST_W, 3, width of the burst_n input.

Ports:
- clk  in  1  tick clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low forces the block idle
- mode  in  2  pattern: 0 OFF, 1 ALT, 2 ALL, 3 BURST
- period  in  CNT_W  clocks per step; 0 is treated as 1
- burst_n  in  BURST_W  flashes per group in BURST mode; 0 is treated as 1
- led_select  in  N_LED  per-LED enable mask
- led_out  out  N_LED  registered LED drive
- busy  out  1  high when the state is not IDLE
- grp_b  out  1  high while group B owns the current step

Behaviour:
- Reset: asynchronous, active-low, on clk. Clears led_out=0, busy=0, grp_b=0, state=IDLE, step counter=0, burst counter=0, latched config=0.
- States: IDLE, A_ON, A_OFF, B_ON, B_OFF.
  - Pattern per state: A_ON = group A mask (for ALL mode: all-ones). A_OFF = 0. B_ON = group B mask. B_OFF = 0.
- All outputs are registered and updated on the same edge as the state.
  - led_out = pattern(next_state) & led_select.
  - A led_select change with no state change appears on led_out one clock later.
- Config latch: mode, period (0->1) and burst_n (0->1) are latched on IDLE exit and at every cycle boundary only. Inputs changed mid-cycle have no effect until the next boundary.
- IDLE: leaves when en=1 and mode!=0. On that edge it goes to A_ON, loads step counter=0, and led_out takes the A pattern. With mode=0 or en=0 it stays in IDLE with led_out=0.
- Step timing:
  - Each non-IDLE state lasts exactly P clocks, where P is the latched period. The counter counts 0..P-1.
  - On the edge where the counter equals P-1 it wraps to 0 and the transition is taken.
- ALT: A_ON -> B_ON -> A_ON ... Cycle boundary at B_ON exit.
- ALL: A_ON (all selected LEDs on) -> A_OFF -> A_ON ... Cycle boundary at A_OFF exit.
- BURST:
  - Sequence: A_ON -> A_OFF repeated burst_n times, then B_ON -> B_OFF repeated burst_n times.
  - The burst counter increments on each OFF exit and clears on group change.
  - Cycle boundary at the final B_OFF exit.
- At a cycle boundary:
  - If the new latched mode is 0, go to IDLE with led_out=0.
  - Otherwise go to A_ON of the new mode.
- en low in any state: on the next edge go to IDLE, led_out=0, counters cleared. A later en restarts at A_ON with fresh config.
- en and mode are checked every clock for the en-low case only. A mode change never aborts a cycle early.
- grp_b = 1 in B_ON/B_OFF, 0 otherwise. busy = (state != IDLE).
- Asynchronous reset mid-step: immediate return to the reset values; no partial flash completes.
- Step counter width CNT_W. No overflow is possible because the count is always < P <= 2^CNT_W-1.

Test Plan:
- Reset held with en=1, mode=1 -> led_out=0x00, busy=0; the first A_ON edge occurs one clock after rst_n release.
- N_LED=8, ALT, period=3, led_select=0xFF, en=1 -> led_out 0xF0 for 3 clk, 0x0F for 3 clk, repeating; grp_b follows the 0x0F phase.
- BURST, period=2, burst_n=2 -> led_out sequence 0xF0,0x00,0xF0,0x00,0x0F,0x00,0x0F,0x00, each held 2 clk, then repeats.
- ALT running, switch to mode=2 midway through B_ON -> B_ON completes its full 3 clk, then 0xFF/0x00 alternation begins at the boundary.
- en dropped mid A_ON -> led_out=0x00 and busy=0 on the next edge; en re-raised -> restart at 0xF0 with a full period.
- period=0, burst_n=0, ALL, led_select=0x81 -> led_out toggles 0x81/0x00 every clock; rst_n pulsed mid-run -> outputs are 0 immediately.
